hazard_unit: RTL and testbench
==============================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have ports: clk_i  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have: rst_i  in  1  reset, synchronous, active-high.
REQ-003 SHALL have: IDEX_MemRd_i  in  1  instruction in EX is a load.
REQ-004 SHALL have: IDEX_RegWrite_i  in  1  instruction in EX writes a register.
REQ-005 SHALL have: IDEX_Dst_i  in  5  EX destination register, after RegDst selection.
REQ-006 SHALL have: IFID_Rs_i  in  5  and  IFID_Rt_i  in  5  source registers of the instruction in ID.
REQ-007 SHALL have: IFID_Branch_i  in  1  instruction in ID is a branch (resolved in ID).
REQ-008 SHALL have: BranchTaken_i  in  1  and  Jump_i  in  1  ID-stage redirect requests.
REQ-009 SHALL have: PCWrite_o  out  1  PC update enable.
REQ-010 SHALL have: IFIDWrite_o  out  1  IF/ID register load enable.
REQ-011 SHALL have: IDEX_Bubble_o  out  1  forces all ID/EX control fields to 0.
REQ-012 SHALL have: IFID_Flush_o  out  1  zeroes the IF/ID instruction.
REQ-013 SHALL have, only with HAZARD_PERF_EN: StallCnt_o  out  32  and  FlushCnt_o  out  32.

Function
REQ-014 SHALL define match as Dst != 0 and (Dst == IFID_Rs_i or Dst == IFID_Rt_i).
REQ-015 SHALL detect a load-use hazard when IDEX_MemRd_i and match: 1 stall cycle; 2 stall cycles if IFID_Branch_i is also set.
REQ-016 SHALL detect a branch-ALU hazard when IFID_Branch_i, IDEX_RegWrite_i, !IDEX_MemRd_i and match: 1 stall cycle.
REQ-017 SHALL, in a stall cycle, drive PCWrite_o=0, IFIDWrite_o=0, IDEX_Bubble_o=1, IFID_Flush_o=0.
REQ-018 SHALL, outside stall cycles, drive PCWrite_o=1, IFIDWrite_o=1, IDEX_Bubble_o=0.
REQ-019 SHALL use FSM states IDLE and STALL, plus a 2-bit remaining-stall counter.
REQ-020 IDLE: hazard detection is combinational, with zero latency. A 1-cycle hazard stalls the current cycle and stays in IDLE. A 2-cycle hazard stalls the current cycle, then goes to STALL with counter=1.
REQ-021 STALL: SHALL stall unconditionally and ignore hazard inputs. SHALL decrement the counter. SHALL return to IDLE when the counter reaches 0, then re-evaluate hazards in that cycle.
REQ-022 SHALL assert IFID_Flush_o = (BranchTaken_i or Jump_i) only in non-stall cycles.
REQ-023 SHALL give stall priority over flush when both occur in the same cycle; the redirect is re-presented by ID after the stall.
REQ-024 SHALL treat register 0 as never hazardous.

Reset
REQ-025 SHALL, while rst_i=1, force state=IDLE and counter=0.
REQ-026 SHALL, while rst_i=1, drive PCWrite_o=1, IFIDWrite_o=1, IDEX_Bubble_o=0, IFID_Flush_o=0, overriding all inputs.
REQ-027 SHALL abort a reset asserted mid-STALL at the next edge, with no residual stall after release.
REQ-028 SHALL reset StallCnt_o and FlushCnt_o to 0 when present.

Configuration
REQ-029 SHALL gate performance counters with macro HAZARD_PERF_EN.
REQ-030 With HAZARD_PERF_EN: StallCnt_o increments on each stall cycle, FlushCnt_o increments on each flush cycle, and both saturate at 32'hFFFFFFFF.
REQ-031 Without HAZARD_PERF_EN: the counter ports and logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-032 SHALL take REG_IDX_W=5, ZERO_REG=0 and the state enum {IDLE, STALL} from shared package pipe_pkg.
REQ-033 SHALL implement each saturating counter as sub-module hazard_perf_cnt, instantiated twice, only under HAZARD_PERF_EN.

Verification
REQ-034 Load-use case: EX load with Dst=5; ID Rs=5, not a branch. Required response: exactly 1 cycle with PCWrite_o=0 and IDEX_Bubble_o=1, then normal operation.
REQ-035 Load-branch case: EX load with Dst=8; ID branch with Rt=8. Required response: 2 consecutive stall cycles, the FSM visits STALL, and StallCnt_o=2.
REQ-036 Branch-ALU case: EX RegWrite with Dst=3, not a load; ID branch with Rs=3. Required response: 1 stall cycle. With Dst=0, there SHALL be no stall.
REQ-037 Stall plus redirect: load-use hazard and BranchTaken_i=1 in the same cycle. Required response: IFID_Flush_o=0 that cycle; IFID_Flush_o=1 in the next cycle if the redirect is held, and FlushCnt_o=1.
REQ-038 Reset mid-stall: assert rst_i in the first cycle of a 2-cycle stall. Required response: at the next edge, state=IDLE and the counters are 0; after release, outputs are 1/1/0/0 with no stall.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline constants, hazard FSM state type and register-match helper
// Contents: REG_IDX_W, ZERO_REG, STALL_CNT_W, hz_state_e {IDLE, STALL}, reg_match().
package pipe_pkg;

    localparam int REG_IDX_W   = 5;
    localparam int STALL_CNT_W = 2;
    localparam int PERF_CNT_W  = 32;

    localparam logic [REG_IDX_W-1:0] ZERO_REG = '0;

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } hz_state_e;

    // Register 0 is hardwired, so a write to it can never create a dependency.
    function automatic logic reg_match(
        input logic [REG_IDX_W-1:0] dst,
        input logic [REG_IDX_W-1:0] rs,
        input logic [REG_IDX_W-1:0] rt
    );
        return (dst != ZERO_REG) && ((dst == rs) || (dst == rt));
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// rtl/hazard_unit_if.sv - hazard detection bundle between pipeline and hazard unit
// Pipeline -> unit: IDEX_MemRd_i, IDEX_RegWrite_i, IDEX_Dst_i, IFID_Rs_i, IFID_Rt_i,
//                   IFID_Branch_i, BranchTaken_i, Jump_i
// Unit -> pipeline: PCWrite_o, IFIDWrite_o, IDEX_Bubble_o, IFID_Flush_o,
//                   StallCnt_o / FlushCnt_o (only with HAZARD_PERF_EN)
// master = pipeline side, slave = hazard unit side.
interface hazard_unit_if;
    import pipe_pkg::*;

    logic                 IDEX_MemRd_i;
    logic                 IDEX_RegWrite_i;
    logic [REG_IDX_W-1:0] IDEX_Dst_i;
    logic [REG_IDX_W-1:0] IFID_Rs_i;
    logic [REG_IDX_W-1:0] IFID_Rt_i;
    logic                 IFID_Branch_i;
    logic                 BranchTaken_i;
    logic                 Jump_i;

    logic                 PCWrite_o;
    logic                 IFIDWrite_o;
    logic                 IDEX_Bubble_o;
    logic                 IFID_Flush_o;

`ifdef HAZARD_PERF_EN
    logic [PERF_CNT_W-1:0] StallCnt_o;
    logic [PERF_CNT_W-1:0] FlushCnt_o;

    modport master (
        output IDEX_MemRd_i, IDEX_RegWrite_i, IDEX_Dst_i, IFID_Rs_i, IFID_Rt_i,
               IFID_Branch_i, BranchTaken_i, Jump_i,
        input  PCWrite_o, IFIDWrite_o, IDEX_Bubble_o, IFID_Flush_o,
               StallCnt_o, FlushCnt_o
    );

    modport slave (
        input  IDEX_MemRd_i, IDEX_RegWrite_i, IDEX_Dst_i, IFID_Rs_i, IFID_Rt_i,
               IFID_Branch_i, BranchTaken_i, Jump_i,
        output PCWrite_o, IFIDWrite_o, IDEX_Bubble_o, IFID_Flush_o,
               StallCnt_o, FlushCnt_o
    );
`else
    modport master (
        output IDEX_MemRd_i, IDEX_RegWrite_i, IDEX_Dst_i, IFID_Rs_i, IFID_Rt_i,
               IFID_Branch_i, BranchTaken_i, Jump_i,
        input  PCWrite_o, IFIDWrite_o, IDEX_Bubble_o, IFID_Flush_o
    );

    modport slave (
        input  IDEX_MemRd_i, IDEX_RegWrite_i, IDEX_Dst_i, IFID_Rs_i, IFID_Rt_i,
               IFID_Branch_i, BranchTaken_i, Jump_i,
        output PCWrite_o, IFIDWrite_o, IDEX_Bubble_o, IFID_Flush_o
    );
`endif

endinterface

// File: rtl/hazard_perf_cnt.sv
// rtl/hazard_perf_cnt.sv - saturating event counter for hazard statistics
// Ports: clk_i (clock), rst_i (sync active-high reset), inc_i (count this cycle),
//        cnt_o (current count, sticks at all-ones).
module hazard_perf_cnt #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] r_cnt;
    logic [W-1:0] w_one;

    assign w_one = {{(W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (inc_i && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + w_one;
        end
    end

    assign cnt_o = r_cnt;

endmodule

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - load-use / branch-operand hazard detection with stall and flush control
// Ports: clk_i (clock), rst_i (sync active-high reset),
//        bus (hazard_unit_if.slave: EX/ID register info in, stall/flush controls out).
// Optional feature: HAZARD_PERF_EN adds saturating StallCnt_o / FlushCnt_o counters.
module hazard_unit
    import pipe_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_i,
    hazard_unit_if.slave  bus
);

    hz_state_e              r_state;
    hz_state_e              w_state_nxt;
    logic [STALL_CNT_W-1:0] r_cnt;
    logic [STALL_CNT_W-1:0] w_cnt_nxt;

    logic w_match;
    logic w_load_use;
    logic w_branch_alu;
    logic w_hazard;
    logic w_two_cycle;
    logic w_stall;
    logic w_stall_eff;
    logic w_flush_eff;

    assign w_match      = reg_match(bus.IDEX_Dst_i, bus.IFID_Rs_i, bus.IFID_Rt_i);
    assign w_load_use   = bus.IDEX_MemRd_i && w_match;
    // A branch compares in ID, so an ALU result still in EX is not yet forwardable.
    assign w_branch_alu = bus.IFID_Branch_i && bus.IDEX_RegWrite_i &&
                          !bus.IDEX_MemRd_i && w_match;
    assign w_hazard     = w_load_use || w_branch_alu;
    // Load feeding a branch needs the data through MEM before ID can compare.
    assign w_two_cycle  = w_load_use && bus.IFID_Branch_i;

    // In STALL the hazard inputs are stale (ID is frozen), so they are ignored.
    assign w_stall      = (r_state == STALL) || w_hazard;
    assign w_stall_eff  = !rst_i && w_stall;
    assign w_flush_eff  = !rst_i && !w_stall && (bus.BranchTaken_i || bus.Jump_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_two_cycle) begin
                    w_state_nxt = STALL;
                    w_cnt_nxt   = 2'd1;
                end else begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            STALL: begin
                // A zero count here is unreachable; leaving is the safe recovery.
                if (r_cnt <= 2'd1) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_state_nxt = STALL;
                    w_cnt_nxt   = r_cnt - 2'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        bus.PCWrite_o     = 1'b1;
        bus.IFIDWrite_o   = 1'b1;
        bus.IDEX_Bubble_o = 1'b0;
        bus.IFID_Flush_o  = 1'b0;
        if (w_stall_eff) begin
            bus.PCWrite_o     = 1'b0;
            bus.IFIDWrite_o   = 1'b0;
            bus.IDEX_Bubble_o = 1'b1;
        end else begin
            // Stall wins over a redirect; ID re-presents the redirect afterwards.
            bus.IFID_Flush_o  = w_flush_eff;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [PERF_CNT_W-1:0] w_stall_cnt;
    logic [PERF_CNT_W-1:0] w_flush_cnt;

    hazard_perf_cnt #(.W(PERF_CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (w_stall_eff),
        .cnt_o (w_stall_cnt)
    );

    hazard_perf_cnt #(.W(PERF_CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (w_flush_eff),
        .cnt_o (w_flush_cnt)
    );

    assign bus.StallCnt_o = w_stall_cnt;
    assign bus.FlushCnt_o = w_flush_cnt;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - self-checking bench for hazard_unit (directed cases plus random stimulus)
module tb_hazard_unit;
    import pipe_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    hazard_unit_if bus_if ();

    hazard_unit dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_if)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model: number of further stall cycles owed, plus event tallies.
    int          m_pending   = 0;
    logic [31:0] m_stall_cnt = '0;
    logic [31:0] m_flush_cnt = '0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, obs, exp);
    endtask

    task automatic run_cycle(input logic r, input logic memrd, input logic regwr,
                             input logic [4:0] dst, input logic [4:0] rs, input logic [4:0] rt,
                             input logic br, input logic bt, input logic jmp);
        logic dep, load_use, br_alu, e_stall, e_flush;
        @(negedge clk);
        cyc++;
        rst                    = r;
        bus_if.IDEX_MemRd_i    = memrd;
        bus_if.IDEX_RegWrite_i = regwr;
        bus_if.IDEX_Dst_i      = dst;
        bus_if.IFID_Rs_i       = rs;
        bus_if.IFID_Rt_i       = rt;
        bus_if.IFID_Branch_i   = br;
        bus_if.BranchTaken_i   = bt;
        bus_if.Jump_i          = jmp;
        #1;
        dep      = (dst != 5'd0) && ((dst == rs) || (dst == rt));
        load_use = memrd && dep;
        br_alu   = br && regwr && !memrd && dep;
        if (r)                  e_stall = 1'b0;
        else if (m_pending > 0) e_stall = 1'b1;
        else                    e_stall = load_use || br_alu;
        e_flush = !r && !e_stall && (bt || jmp);

        check_eq("PCWrite_o",     32'(bus_if.PCWrite_o),     32'(!e_stall));
        check_eq("IFIDWrite_o",   32'(bus_if.IFIDWrite_o),   32'(!e_stall));
        check_eq("IDEX_Bubble_o", 32'(bus_if.IDEX_Bubble_o), 32'(e_stall));
        check_eq("IFID_Flush_o",  32'(bus_if.IFID_Flush_o),  32'(e_flush));
        check_eq("in_stall_state", 32'(dut.r_state == STALL), 32'(m_pending > 0));
`ifdef HAZARD_PERF_EN
        check_eq("StallCnt_o", bus_if.StallCnt_o, m_stall_cnt);
        check_eq("FlushCnt_o", bus_if.FlushCnt_o, m_flush_cnt);
`endif
        if (r) begin
            m_pending   = 0;
            m_stall_cnt = '0;
            m_flush_cnt = '0;
        end else begin
            if (m_pending > 0)             m_pending = m_pending - 1;
            else if (load_use && br)       m_pending = 1;
            if (e_stall && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt = m_stall_cnt + 1;
            if (e_flush && m_flush_cnt != 32'hFFFF_FFFF) m_flush_cnt = m_flush_cnt + 1;
        end
    endtask

    initial begin
        bus_if.IDEX_MemRd_i    = 1'b0;
        bus_if.IDEX_RegWrite_i = 1'b0;
        bus_if.IDEX_Dst_i      = '0;
        bus_if.IFID_Rs_i       = '0;
        bus_if.IFID_Rt_i       = '0;
        bus_if.IFID_Branch_i   = 1'b0;
        bus_if.BranchTaken_i   = 1'b0;
        bus_if.Jump_i          = 1'b0;

        // Reset overrides a live hazard and redirect.
        run_cycle(1, 1, 1, 5'd5, 5'd5, 5'd0, 1, 1, 1);
        run_cycle(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);

        // Load-use: one stall then normal.
        run_cycle(0, 1, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0);
        run_cycle(0, 0, 0, 5'd0, 5'd5, 5'd0, 0, 0, 0);

        // Load feeding a branch: two stalls, second ignores inputs.
        run_cycle(0, 1, 1, 5'd8, 5'd0, 5'd8, 1, 0, 0);
        run_cycle(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
        run_cycle(0, 0, 0, 5'd0, 5'd8, 5'd0, 1, 0, 0);

        // Branch-ALU: one stall; destination r0 never stalls.
        run_cycle(0, 0, 1, 5'd3, 5'd3, 5'd0, 1, 0, 0);
        run_cycle(0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 0, 0);
        run_cycle(0, 1, 1, 5'd0, 5'd0, 5'd0, 1, 0, 0);

        // Stall with redirect: flush held off, then taken next cycle.
        run_cycle(0, 1, 1, 5'd5, 5'd5, 5'd0, 0, 1, 0);
        run_cycle(0, 0, 0, 5'd0, 5'd5, 5'd0, 0, 1, 0);
        run_cycle(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1);

        // Reset during the STALL cycle of a 2-cycle stall.
        run_cycle(0, 1, 1, 5'd8, 5'd0, 5'd8, 1, 0, 0);
        run_cycle(1, 1, 1, 5'd8, 5'd0, 5'd8, 1, 0, 0);
        run_cycle(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        // Reset in the first cycle of a 2-cycle stall.
        run_cycle(1, 1, 1, 5'd8, 5'd0, 5'd8, 1, 0, 0);
        run_cycle(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            run_cycle(($urandom_range(0, 39) == 0),
                      1'($urandom), 1'($urandom),
                      5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                      5'($urandom_range(0, 3)),
                      1'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
